// File: rtl/pipe_stage_tracker.sv
// IF/ID .. MEM/WB instruction register bank driven by hazard-unit clear/load
// controls, with rd write-enable decode and saturating retire/stall/flush counters.

module pst_stage_reg #(
   parameter logic [31:0] NOP = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_n,
   input  logic        load,
   input  logic [31:0] d_instr,
   input  logic        d_valid,
   output logic [31:0] q_instr,
   output logic        q_valid
);

   // Clear beats load; a held stage keeps both instruction and valid.
   always_ff @(posedge clk) begin
      if (reset || !clr_n) begin
         q_instr <= NOP;
         q_valid <= 1'b0;
      end else if (load) begin
         q_instr <= d_instr;
         q_valid <= d_valid;
      end
   end

endmodule

module pipe_stage_tracker #(
   parameter int          CNT_W = 32,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      i_instr_if,
   input  logic             i_instr_valid,
   input  logic             i_reset_if,
   input  logic             i_enable_if,
   input  logic             i_reset_id,
   input  logic             i_enable_id,
   input  logic             i_reset_ex,
   input  logic             i_enable_ex,
   input  logic             i_reset_mem,
   input  logic             i_enable_mem,
   output logic [31:0]      instr_id,
   output logic [31:0]      instr_ex,
   output logic [31:0]      instr_mem,
   output logic [31:0]      instr_wb,
   output logic             valid_id,
   output logic             valid_ex,
   output logic             valid_mem,
   output logic             valid_wb,
   output logic             rd_wren_ex,
   output logic             rd_wren_mem,
   output logic             rd_wren_wb,
   output logic [CNT_W-1:0] o_retire_cnt,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam int STAGES = 4;
   localparam int NCNT   = 3;

   function automatic logic writes_rd(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                        7'b1100111, 7'b0110111, 7'b0010111};
   endfunction

   logic [STAGES-1:0]        clr_n, ld_en;
   logic [STAGES-1:0][31:0]  src_instr, stage_instr;
   logic [STAGES-1:0]        src_valid, stage_valid;
   logic [STAGES-2:0]        wren;

   assign clr_n     = {i_reset_mem, i_reset_ex, i_reset_id, i_reset_if};
   assign ld_en     = {i_enable_mem, i_enable_ex, i_enable_id, i_enable_if};
   assign src_instr = {stage_instr[STAGES-2:0], i_instr_if};
   assign src_valid = {stage_valid[STAGES-2:0], i_instr_valid};

   generate
      for (genvar s = 0; s < STAGES; s++) begin : g_stage
         pst_stage_reg #(.NOP(NOP)) u_stage (
            .clk     (i_clk),
            .reset   (i_reset),
            .clr_n   (clr_n[s]),
            .load    (ld_en[s]),
            .d_instr (src_instr[s]),
            .d_valid (src_valid[s]),
            .q_instr (stage_instr[s]),
            .q_valid (stage_valid[s])
         );
      end
      // Only EX onward is inspected by the hazard unit for rd writes.
      for (genvar s = 1; s < STAGES; s++) begin : g_wren
         assign wren[s-1] = stage_valid[s] && writes_rd(stage_instr[s][6:0]);
      end
   endgenerate

   assign {instr_wb, instr_mem, instr_ex, instr_id} = stage_instr;
   assign {valid_wb, valid_mem, valid_ex, valid_id} = stage_valid;
   assign {rd_wren_wb, rd_wren_mem, rd_wren_ex}     = wren;

   logic [NCNT-1:0]             cnt_ev;
   logic [NCNT-1:0][CNT_W-1:0]  cnt;

   assign cnt_ev[0] = i_reset_mem && i_enable_mem && stage_valid[2];
   assign cnt_ev[1] = i_reset_if && !i_enable_if;
   assign cnt_ev[2] = !i_reset_if;

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < NCNT; k++) begin
         if (i_reset)
            cnt[k] <= '0;
         else if (cnt_ev[k] && !(&cnt[k]))
            cnt[k] <= cnt[k] + CNT_W'(1);
      end
   end

   assign o_retire_cnt = cnt[0];
   assign o_stall_cnt  = cnt[1];
   assign o_flush_cnt  = cnt[2];

endmodule

// File: doc/pipe_stage_tracker.md
# pipe_stage_tracker

Pipeline-register bank and event counter that consumes the per-stage clear/enable controls produced by the hazard detection unit and produces the stage instructions and write-enable flags that unit inspects. Holds the IF/ID, ID/EX, EX/MEM and MEM/WB instruction registers with valid bits, inserts NOP bubbles on clear, and holds on stall. Keeps saturating counters of retired instructions, stall cycles and flush cycles for performance debug.

## Interface
- CNT_W, 32, width of each event counter
- NOP, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high; overrides every other input
- i_instr_if  in  32  instruction fetched this cycle
- i_instr_valid  in  1  i_instr_if is a real instruction
- i_reset_if / i_enable_if  in  1/1  IF/ID register: active-low clear / active-high load
- i_reset_id / i_enable_id  in  1/1  ID/EX register: active-low clear / load
- i_reset_ex / i_enable_ex  in  1/1  EX/MEM register: active-low clear / load
- i_reset_mem / i_enable_mem  in  1/1  MEM/WB register: active-low clear / load
- instr_id, instr_ex, instr_mem, instr_wb  out  32 each  registered stage instructions
- valid_id, valid_ex, valid_mem, valid_wb  out  1 each  stage holds a real instruction
- rd_wren_ex, rd_wren_mem, rd_wren_wb  out  1 each  stage instruction writes rd
- o_retire_cnt, o_stall_cnt, o_flush_cnt  out  CNT_W each  event counters

## Operation
- Per stage register (X = if/id/ex/mem), priority per cycle: i_reset high → NOP, valid 0; else i_reset_X==0 → NOP, valid 0 (clear wins over enable); else i_enable_X==1 → load from upstream; else hold.
- Upstream sources: IF/ID ← i_instr_if/i_instr_valid; ID/EX ← instr_id/valid_id; EX/MEM ← instr_ex/valid_ex; MEM/WB ← instr_mem/valid_mem.
- rd_wren_S = valid_S && opcode(instr_S) ∈ {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111}; stores, branches, system → 0. rd==x0 does not mask (hazard unit filters x0).
- Retire: o_retire_cnt += 1 in a cycle where MEM/WB loads (not reset, i_reset_mem==1, i_enable_mem==1) and valid_mem==1.
- Stall: o_stall_cnt += 1 in a cycle with i_reset_if==1 and i_enable_if==0.
- Flush: o_flush_cnt += 1 in a cycle with i_reset_if==0.
- Counters saturate at 2^CNT_W-1; no wrap.
- Data-hazard pattern (id clear, if hold): IF/ID keeps its instruction, bubble enters EX, EX/MEM and MEM/WB advance. Control-hazard pattern (if and id clear): bubbles enter ID and EX.

## Timing
- Reset (i_reset high at edge): all instr_* = NOP, all valid_* = 0, all rd_wren_* = 0, all counters 0; effective on next edge, regardless of other inputs; mid-stream reset discards in-flight instructions with no retire counted.
- Stage registers: one-cycle latency per stage; instruction with i_instr_valid at edge N appears on instr_id after N, instr_wb after N+3 with no stalls.
- rd_wren_* combinational from registered instr/valid, so settle in the same cycle as instr_*; no combinational path from clear/enable inputs to any output.
- Counter increments visible the cycle after the qualifying edge.
- Clear and load inputs of different stages are independent; simultaneous clear of a stage and load of the next stage moves the old content downstream while the stage becomes a bubble.

## Test plan
- Reset: drive i_reset 1 for 2 cycles with random controls → instr_* = 32'h0000_0013, valid_* = 0, counters 0.
- Straight flow: feed 32'h00500093 (addi x1) then 32'h00208133 (add x2), all enables 1, clears 1 → instr_wb = 32'h00500093 four edges after first feed, rd_wren_wb=1, o_retire_cnt=2 after both reach WB.
- Stall: hold i_reset_id=0, i_enable_if=0 for 2 cycles with 32'h00208133 in ID → instr_id unchanged, two NOPs reach EX, o_stall_cnt=2, then advances.
- Flush: i_reset_if=0, i_reset_id=0 one cycle → valid_id=0, valid_ex=0, instr_id=instr_ex=NOP, o_flush_cnt=1, downstream unchanged flow.
- Store/branch: pass 32'h0020a023 (sw) and 32'h00208463 (beq) → rd_wren_ex/mem/wb stay 0 while they traverse; retire count still increments.
- Saturation: CNT_W=4, 20 stall cycles → o_stall_cnt = 4'hF and holds.
